chess_timer_ctrl: RTL and testbench

- Countdown engine for the two player clocks of the chess counter.
- Consumes the one-hot game-state outputs (p1, p2, Load, ff) from the game-state FSM.
- Runs a 1 s prescaler and decrements the active player's remaining time.
- Detects flag-fall and freezes both clocks until the game is reloaded or reset.

---
 rtl/chess_timer_pkg.sv | 33 +++
 rtl/chess_timer_ctrl_prescaler.sv | 39 +++
 rtl/chess_timer_ctrl.sv | 169 ++++++++++++++++
 tb/tb_chess_timer_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/chess_timer_pkg.sv
// Shared types, default parameters and saturating arithmetic helpers for
// the chess timer countdown engine.
package chess_timer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_P1 = 3'd1,
    RUN_P2 = 3'd2,
    HOLD   = 3'd3,
    OVER   = 3'd4
  } state_e;

  localparam int unsigned CLK_HZ_DEF       = 50000000;
  localparam int unsigned TIME_W_DEF       = 12;
  localparam int unsigned DEFAULT_TIME_DEF = 300;
  localparam int unsigned INC_SEC_DEF      = 2;

  // a + b, clamped to max_v.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
  endfunction

  // a - b, clamped to zero.
  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/chess_timer_ctrl_prescaler.sv
// sec_prescaler: divides the system clock down to one charge per second.
// wrap_o flags the terminal count; the owner decides whether that edge
// actually charges a second (it is combined with its own enable).
module sec_prescaler
  import chess_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ = CLK_HZ_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign wrap_o = (cnt_q == LAST);

endmodule

// File: rtl/chess_timer_ctrl.sv
// chess_timer_ctrl: two-player countdown engine driven by the one-hot
// game-state outputs. Flag-fall freezes both clocks until ff/Load.
// Optional build macro: FISCHER_INCREMENT_EN adds INC_SEC to the player
// who just completed a move on each direct RUN_P1<->RUN_P2 handover.
module chess_timer_ctrl
  import chess_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
  parameter int unsigned TIME_W       = TIME_W_DEF,
  parameter int unsigned DEFAULT_TIME = DEFAULT_TIME_DEF,
  parameter int unsigned INC_SEC      = INC_SEC_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              p1,
  input  logic              p2,
  input  logic              Load,
  input  logic              ff,
  input  logic [TIME_W-1:0] load_time,
  output logic [TIME_W-1:0] p1_time,
  output logic [TIME_W-1:0] p2_time,
  output logic              p1_flag,
  output logic              p2_flag,
  output logic              sec_tick,
  output logic              game_over
);

  localparam logic [TIME_W-1:0] DEF_T    = TIME_W'(DEFAULT_TIME);
  localparam logic [31:0]       TIME_MAX = 32'((64'd1 << TIME_W) - 64'd1);

`ifdef FISCHER_INCREMENT_EN
  localparam logic [31:0] FISCHER_INC = 32'(INC_SEC);
`else
  // Increment compiled out: a zero step leaves the handover times untouched.
  localparam logic [31:0] FISCHER_INC = 32'(INC_SEC) & 32'd0;
`endif

  state_e            state_q, state_d;
  logic [TIME_W-1:0] p1_time_q, p1_time_d, p2_time_q, p2_time_d;
  logic              p1_flag_q, p1_flag_d, p2_flag_q, p2_flag_d;
  logic              tick_q, tick_d;
  logic              over_q, over_d;

  logic              want_p1, want_p2;
  logic              pre_clr, pre_en, pre_wrap;

  // p1=p2=1 is illegal and decodes as "neither".
  assign want_p1 = p1 & ~p2;
  assign want_p2 = p2 & ~p1;

  sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .clk_i (Clock),
    .rst_ni(Reset),
    .clr_i (pre_clr),
    .en_i  (pre_en),
    .wrap_o(pre_wrap)
  );

  // Next state, prescaler control and counter updates; ff > Load > turn change > tick.
  always_comb begin
    state_d   = state_q;
    p1_time_d = p1_time_q;
    p2_time_d = p2_time_q;
    p1_flag_d = p1_flag_q;
    p2_flag_d = p2_flag_q;
    tick_d    = 1'b0;
    pre_clr   = 1'b0;
    pre_en    = 1'b0;

    if (ff) begin
      state_d   = IDLE;
      p1_time_d = DEF_T;
      p2_time_d = DEF_T;
      p1_flag_d = 1'b0;
      p2_flag_d = 1'b0;
      pre_clr   = 1'b1;
    end else if (Load) begin
      state_d   = IDLE;
      p1_time_d = (load_time == '0) ? DEF_T : load_time;
      p2_time_d = (load_time == '0) ? DEF_T : load_time;
      p1_flag_d = 1'b0;
      p2_flag_d = 1'b0;
      pre_clr   = 1'b1;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (want_p1)      state_d = RUN_P1;
          else if (want_p2) state_d = RUN_P2;
        end
        RUN_P1: begin
          if (p1_flag_q) begin
            state_d = OVER;
          end else if (want_p2) begin
            // Handover: any coincident terminal count is dropped uncharged.
            state_d   = RUN_P2;
            pre_clr   = 1'b1;
            p1_time_d = TIME_W'(sat_add(32'(p1_time_q), FISCHER_INC, TIME_MAX));
          end else begin
            pre_en = 1'b1;
            if (!want_p1) state_d = HOLD;
            if (pre_wrap) begin
              tick_d    = 1'b1;
              p1_time_d = TIME_W'(sat_sub(32'(p1_time_q), 32'd1));
              if (p1_time_q == TIME_W'(1)) begin
                p1_flag_d = 1'b1;
                state_d   = OVER;
              end
            end
          end
        end
        RUN_P2: begin
          if (p2_flag_q) begin
            state_d = OVER;
          end else if (want_p1) begin
            state_d   = RUN_P1;
            pre_clr   = 1'b1;
            p2_time_d = TIME_W'(sat_add(32'(p2_time_q), FISCHER_INC, TIME_MAX));
          end else begin
            pre_en = 1'b1;
            if (!want_p2) state_d = HOLD;
            if (pre_wrap) begin
              tick_d    = 1'b1;
              p2_time_d = TIME_W'(sat_sub(32'(p2_time_q), 32'd1));
              if (p2_time_q == TIME_W'(1)) begin
                p2_flag_d = 1'b1;
                state_d   = OVER;
              end
            end
          end
        end
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end

    over_d = (state_d == OVER);
  end

  // State, counters, flags and registered pulse outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      p1_time_q <= DEF_T;
      p2_time_q <= DEF_T;
      p1_flag_q <= 1'b0;
      p2_flag_q <= 1'b0;
      tick_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p1_time_q <= p1_time_d;
      p2_time_q <= p2_time_d;
      p1_flag_q <= p1_flag_d;
      p2_flag_q <= p2_flag_d;
      tick_q    <= tick_d;
      over_q    <= over_d;
    end
  end

  assign p1_time   = p1_time_q;
  assign p2_time   = p2_time_q;
  assign p1_flag   = p1_flag_q;
  assign p2_flag   = p2_flag_q;
  assign sec_tick  = tick_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_chess_timer_ctrl.sv
// Testbench for chess_timer_ctrl with CLK_HZ=4, TIME_W=8, DEFAULT_TIME=5, INC_SEC=2.
module tb_chess_timer_ctrl;

`ifdef FISCHER_INCREMENT_EN
  localparam int FI = 2;
`else
  localparam int FI = 0;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       p1 = 1'b0, p2 = 1'b0, Load = 1'b0, ff = 1'b0;
  logic [7:0] load_time = '0;
  logic [7:0] p1_time, p2_time;
  logic       p1_flag, p2_flag, sec_tick, game_over;

  chess_timer_ctrl #(
    .CLK_HZ(4),
    .TIME_W(8),
    .DEFAULT_TIME(5),
    .INC_SEC(2)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .p1       (p1),
    .p2       (p2),
    .Load     (Load),
    .ff       (ff),
    .load_time(load_time),
    .p1_time  (p1_time),
    .p2_time  (p2_time),
    .p1_flag  (p1_flag),
    .p2_flag  (p2_flag),
    .sec_tick (sec_tick),
    .game_over(game_over)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int p1, p2, ld, ff, lt;
    int e1, e2, f1, f2, go, tk;
  } vec_t;

  typedef struct {
    int idx;
    int e1, e2, f1, f2, go, tk;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input int a, input int b, input int ld, input int f, input int lt,
                     input int e1, input int e2, input int f1, input int f2,
                     input int go, input int tk);
    vec_t v;
    v.p1 = a; v.p2 = b; v.ld = ld; v.ff = f; v.lt = lt;
    v.e1 = e1; v.e2 = e2; v.f1 = f1; v.f2 = f2; v.go = go; v.tk = tk;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  // Scoreboard consumer: compares registered outputs just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("p1_time",   e.idx, 32'(p1_time),   e.e1);
        chk("p2_time",   e.idx, 32'(p2_time),   e.e2);
        chk("p1_flag",   e.idx, 32'(p1_flag),   e.f1);
        chk("p2_flag",   e.idx, 32'(p2_flag),   e.f2);
        chk("game_over", e.idx, 32'(game_over), e.go);
        chk("sec_tick",  e.idx, 32'(sec_tick),  e.tk);
      end
    end
  end

  initial begin
    exp_t e;

    // Idle after reset: no ticks.
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, 5,5,0,0,0,0);
    // Load 3 then run p1 to flag-fall.
    add(0,0,1,0,3, 3,3,0,0,0,0);
    for (int i = 1; i <= 12; i++)
      add(1,0,0,0,0, (i <= 4) ? 3 : (i <= 8) ? 2 : 1, 3, 0,0,0, (i == 5 || i == 9) ? 1 : 0);
    add(0,0,0,0,0, 0,3,1,0,1,1);
    add(0,0,0,0,0, 0,3,1,0,1,0);
    // OVER ignores p2, ff restores defaults.
    add(0,1,0,0,0, 0,3,1,0,1,0);
    add(0,0,0,0,0, 0,3,1,0,1,0);
    add(0,0,0,1,0, 5,5,0,0,0,0);
    // Illegal p1=p2=1 stays idle.
    for (int i = 0; i < 5; i++) add(1,1,0,0,0, 5,5,0,0,0,0);
    // p1 for 6 cycles, handover to p2, then handover on a terminal count.
    for (int i = 1; i <= 6; i++) add(1,0,0,0,0, (i < 5) ? 5 : 4, 5, 0,0,0, (i == 5) ? 1 : 0);
    add(0,1,0,0,0, 4+FI,5,0,0,0,0);
    for (int i = 8; i <= 10; i++) add(0,1,0,0,0, 4+FI,5,0,0,0,0);
    add(0,1,0,0,0, 4+FI,4,0,0,0,1);
    for (int i = 12; i <= 14; i++) add(0,1,0,0,0, 4+FI,4,0,0,0,0);
    add(1,0,0,0,0, 4+FI,4+FI,0,0,0,0);
    for (int i = 16; i <= 18; i++) add(1,0,0,0,0, 4+FI,4+FI,0,0,0,0);
    add(1,0,0,0,0, 3+FI,4+FI,0,0,0,1);
    add(0,0,0,1,0, 5,5,0,0,0,0);
    // Pause: partial count is held across HOLD.
    for (int i = 0; i < 2; i++)  add(1,0,0,0,0, 5,5,0,0,0,0);
    for (int i = 0; i < 10; i++) add(0,0,0,0,0, 5,5,0,0,0,0);
    for (int i = 0; i < 2; i++)  add(1,0,0,0,0, 5,5,0,0,0,0);
    add(0,0,0,0,0, 4,5,0,0,0,1);
    for (int i = 0; i < 3; i++)  add(0,0,0,0,0, 4,5,0,0,0,0);
    // Load with load_time=0 falls back to the default.
    add(0,0,1,0,9, 9,9,0,0,0,0);
    add(0,0,1,0,0, 5,5,0,0,0,0);
    // Run p1 into the middle of a second for the async reset check.
    for (int i = 1; i <= 6; i++) add(1,0,0,0,0, (i < 5) ? 5 : 4, 5, 0,0,0, (i == 5) ? 1 : 0);

    // Asynchronous reset with no clock edge involved.
    #2 Reset = 1'b0;
    #1;
    chk("rst_p1_time",   -1, 32'(p1_time),   5);
    chk("rst_p2_time",   -1, 32'(p2_time),   5);
    chk("rst_flags",     -1, 32'({p1_flag, p2_flag}), 0);
    chk("rst_game_over", -1, 32'(game_over), 0);
    chk("rst_sec_tick",  -1, 32'(sec_tick),  0);
    @(negedge Clock);
    Reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge Clock);
      p1 = 1'(tbl[i].p1); p2 = 1'(tbl[i].p2);
      Load = 1'(tbl[i].ld); ff = 1'(tbl[i].ff);
      load_time = 8'(tbl[i].lt);
      e.idx = i; e.e1 = tbl[i].e1; e.e2 = tbl[i].e2; e.f1 = tbl[i].f1;
      e.f2 = tbl[i].f2; e.go = tbl[i].go; e.tk = tbl[i].tk;
      sb.push_back(e);
    end

    // p1 stays asserted; prescaler is mid-count. Assert reset between edges.
    @(posedge Clock);
    #2;
    chk("sb_drained", -1, 32'(sb.size()), 0);
    chk("pre_rst_p1_time", -1, 32'(p1_time), 4);
    Reset = 1'b0;
    #1;
    chk("mid_rst_p1_time",   -1, 32'(p1_time),   5);
    chk("mid_rst_p2_time",   -1, 32'(p2_time),   5);
    chk("mid_rst_game_over", -1, 32'(game_over), 0);
    chk("mid_rst_sec_tick",  -1, 32'(sec_tick),  0);
    @(negedge Clock);
    p1 = 1'b0;
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    chk("post_rst_idle_p1_time", -1, 32'(p1_time), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
